seq_frame_tx: RTL and testbench

Serial frame transmitter producing the bit stream our 001100 sequence detectors consume. It accepts one parallel data word per valid/ready handshake and emits it serially, one bit per clock, as a frame: a fixed 6-bit preamble, the data word MSB-first, and an optional even-parity bit. A programmable idle gap follows each frame. The block sits on the transmit side of the serial link, feeding the detector/receiver chain.

---
 rtl/seq_frame_tx_if.sv | 24 ++
 rtl/seq_frame_tx.sv | 143 ++++++++++++++
 tb/tb_seq_frame_tx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seq_frame_tx_if.sv
// Handshake and serial-output bundle for seq_frame_tx.
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              out_bit;
  logic              out_valid;
  logic              busy;
  logic              frame_done;

  // Producer / serial-consumer side
  modport master (
    output in_data, in_valid,
    input  in_ready, out_bit, out_valid, busy, frame_done
  );

  // Transmitter side
  modport slave (
    input  in_data, in_valid,
    output in_ready, out_bit, out_valid, busy, frame_done
  );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, optional even
// parity, then a programmable idle gap. One bit per clock.
module seq_frame_tx #(
  parameter int          DATA_W    = 8,
  parameter logic [5:0]  PREAMBLE  = 6'b001100,
  parameter bit          PARITY_EN = 1'b1,
  parameter int          GAP       = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  seq_frame_tx_if.slave bus
);

  localparam int MAXC = (DATA_W > GAP) ? ((DATA_W > 6) ? DATA_W : 6)
                                       : ((GAP > 6) ? GAP : 6);
  localparam int CW   = $clog2(MAXC + 1);
  // Bits still to send after the first preamble bit goes out on the handshake edge
  localparam int SRW  = DATA_W + 5 + int'(PARITY_EN);

  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_DATA, ST_PAR, ST_GAP} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [SRW-1:0] sr;
  logic [SRW-1:0] sr_load;

  // Preamble tail, payload and parity packed into one shift register so every
  // frame bit is taken from the same MSB position.
  always_comb begin
    sr_load = '0;
    sr_load[SRW-1 -: (5 + DATA_W)] = {PREAMBLE[4:0], bus.in_data};
    if (PARITY_EN) sr_load[0] = ^bus.in_data;
  end

  // Frame sequencer with all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      sr             <= '0;
      bus.out_bit    <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.in_ready   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            state         <= ST_PRE;
            cnt           <= CW'(1);
            sr            <= sr_load;
            bus.out_bit   <= PREAMBLE[5];
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b1;
            bus.in_ready  <= 1'b0;
          end else begin
            bus.out_bit   <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end

        ST_PRE: begin
          bus.out_bit <= sr[SRW-1];
          sr          <= sr << 1;
          if (cnt == CW'(6)) begin
            state          <= ST_DATA;
            cnt            <= CW'(1);
            bus.frame_done <= (DATA_W == 1) && !PARITY_EN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (cnt == CW'(DATA_W)) begin
            if (PARITY_EN) begin
              state          <= ST_PAR;
              bus.out_bit    <= sr[SRW-1];
              sr             <= sr << 1;
              bus.frame_done <= 1'b1;
            end else begin
              bus.out_bit   <= 1'b1;
              bus.out_valid <= 1'b0;
              cnt           <= CW'(1);
              if (GAP != 0) begin
                state        <= ST_GAP;
                bus.busy     <= 1'b1;
                bus.in_ready <= 1'b0;
              end else begin
                state        <= ST_IDLE;
                bus.busy     <= 1'b0;
                bus.in_ready <= 1'b1;
              end
            end
          end else begin
            bus.out_bit    <= sr[SRW-1];
            sr             <= sr << 1;
            cnt            <= cnt + CW'(1);
            bus.frame_done <= !PARITY_EN && (cnt == CW'(DATA_W - 1));
          end
        end

        ST_PAR: begin
          bus.out_bit   <= 1'b1;
          bus.out_valid <= 1'b0;
          cnt           <= CW'(1);
          if (GAP != 0) begin
            state        <= ST_GAP;
            bus.busy     <= 1'b1;
            bus.in_ready <= 1'b0;
          end else begin
            state        <= ST_IDLE;
            bus.busy     <= 1'b0;
            bus.in_ready <= 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt == CW'(GAP)) begin
            state        <= ST_IDLE;
            bus.busy     <= 1'b0;
            bus.in_ready <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state         <= ST_IDLE;
          bus.out_bit   <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
          bus.in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: default build plus a 4-bit, no-parity, no-gap build.
module tb_seq_frame_tx;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  int   fd_cnt  = 0;

  seq_frame_tx_if #(.DATA_W(8)) bus0 ();
  seq_frame_tx_if #(.DATA_W(4)) bus1 ();

  seq_frame_tx #(.DATA_W(8), .PREAMBLE(6'b001100), .PARITY_EN(1'b1), .GAP(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  seq_frame_tx #(.DATA_W(4), .PREAMBLE(6'b001100), .PARITY_EN(1'b0), .GAP(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  // 100 MHz-style clock
  always #5 clk = ~clk;

  // Cycle counter for period measurements
  always @(posedge clk) cyc++;

  // Count frame_done pulses of the default instance
  always @(negedge clk) if (bus0.frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the sample point right after the handshake edge; returns at the
  // sample point where in_ready is high again.
  task automatic frame0(input string nm, input logic [14:0] exp, input bit disturb,
                        output int t_first);
    t_first = cyc;
    for (int i = 0; i < 15; i++) begin
      check({nm, "_valid"}, 32'(bus0.out_valid), 32'd1);
      check({nm, "_bit"},   32'(bus0.out_bit),   32'(exp[14-i]));
      check({nm, "_done"},  32'(bus0.frame_done), 32'(i == 14));
      check({nm, "_ready"}, 32'(bus0.in_ready),  32'd0);
      check({nm, "_busy"},  32'(bus0.busy),      32'd1);
      if (disturb) begin
        bus0.in_data  = 8'($urandom);
        bus0.in_valid = i[0];
      end
      tick();
    end
    if (disturb) bus0.in_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check({nm, "_gap_valid"}, 32'(bus0.out_valid), 32'd0);
      check({nm, "_gap_bit"},   32'(bus0.out_bit),   32'd1);
      check({nm, "_gap_busy"},  32'(bus0.busy),      32'd1);
      check({nm, "_gap_ready"}, 32'(bus0.in_ready),  32'd0);
      tick();
    end
    check({nm, "_end_ready"}, 32'(bus0.in_ready),  32'd1);
    check({nm, "_end_busy"},  32'(bus0.busy),      32'd0);
    check({nm, "_end_valid"}, 32'(bus0.out_valid), 32'd0);
  endtask

  initial begin
    int t1, t2, fd_before;
    logic [9:0] exp1;

    bus0.in_data = '0; bus0.in_valid = 1'b0;
    bus1.in_data = '0; bus1.in_valid = 1'b0;

    // Power-on reset
    #1 reset_n = 1'b0;
    #2;
    check("rst_ready", 32'(bus0.in_ready),   32'd0);
    check("rst_bit",   32'(bus0.out_bit),    32'd1);
    check("rst_valid", 32'(bus0.out_valid),  32'd0);
    check("rst_busy",  32'(bus0.busy),       32'd0);
    check("rst_done",  32'(bus0.frame_done), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    check("rel_ready0", 32'(bus0.in_ready), 32'd0);
    tick();
    check("rel_ready1", 32'(bus0.in_ready), 32'd1);
    check("rel_ready1_v", 32'(bus1.in_ready), 32'd1);

    // Single frame 0xA5
    bus0.in_data = 8'hA5; bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    frame0("a5", 15'b001100_10100101_0, 1'b0, t1);

    // Back-to-back 0xFF then 0x07 with in_valid held high
    bus0.in_data = 8'hFF; bus0.in_valid = 1'b1;
    tick();
    bus0.in_data = 8'h07;
    frame0("ff", 15'b001100_11111111_0, 1'b0, t1);
    tick();
    bus0.in_valid = 1'b0;
    frame0("07", 15'b001100_00000111_1, 1'b0, t2);
    check("b2b_period", 32'(t2 - t1), 32'd18);

    // Inputs disturbed while busy
    bus0.in_data = 8'h3C; bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    frame0("3c", 15'b001100_00111100_0, 1'b1, t1);
    bus0.in_data = 8'h55;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_valid", 32'(bus0.out_valid), 32'd0);
      check("idle_ready", 32'(bus0.in_ready),  32'd1);
    end
    check("fd_count", 32'(fd_cnt), 32'd4);

    // Mid-frame reset during 3rd data bit of 0x81
    bus0.in_data = 8'h81; bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("m81_valid", 32'(bus0.out_valid), 32'd1);
    check("m81_bit",   32'(bus0.out_bit),   32'd0);
    fd_before = fd_cnt;
    #2 reset_n = 1'b0;
    #1;
    check("mrst_bit",   32'(bus0.out_bit),    32'd1);
    check("mrst_valid", 32'(bus0.out_valid),  32'd0);
    check("mrst_ready", 32'(bus0.in_ready),   32'd0);
    check("mrst_busy",  32'(bus0.busy),       32'd0);
    check("mrst_done",  32'(bus0.frame_done), 32'd0);
    tick();
    check("mrst_hold_valid", 32'(bus0.out_valid), 32'd0);
    #2;
    reset_n = 1'b1;
    bus0.in_data = 8'h3C; bus0.in_valid = 1'b1;
    tick();
    check("mrel_ready", 32'(bus0.in_ready),  32'd1);
    check("mrel_valid", 32'(bus0.out_valid), 32'd0);
    check("mrel_busy",  32'(bus0.busy),      32'd0);
    check("m81_no_done", 32'(fd_cnt), 32'(fd_before));
    tick();
    bus0.in_valid = 1'b0;
    frame0("r3c", 15'b001100_00111100_0, 1'b0, t1);

    // Variant: DATA_W=4, no parity, no gap
    exp1 = 10'b001100_1011;
    bus1.in_data = 4'hB; bus1.in_valid = 1'b1;
    tick();
    t1 = cyc;
    for (int i = 0; i < 10; i++) begin
      check("v_valid", 32'(bus1.out_valid),  32'd1);
      check("v_bit",   32'(bus1.out_bit),    32'(exp1[9-i]));
      check("v_done",  32'(bus1.frame_done), 32'(i == 9));
      check("v_ready", 32'(bus1.in_ready),   32'd0);
      tick();
    end
    check("v_end_ready", 32'(bus1.in_ready),  32'd1);
    check("v_end_busy",  32'(bus1.busy),      32'd0);
    check("v_end_valid", 32'(bus1.out_valid), 32'd0);
    check("v_end_bit",   32'(bus1.out_bit),   32'd1);
    tick();
    bus1.in_valid = 1'b0;
    check("v2_valid",  32'(bus1.out_valid), 32'd1);
    check("v2_bit",    32'(bus1.out_bit),   32'd0);
    check("v_period",  32'(cyc - t1),       32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
